// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR sample sequencer: FSM states,
// APB register word indices, CTRL/STATUS bit positions.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE
    } state_t;

    typedef logic [9:0] word_t;

    localparam word_t W_CTRL       = 10'd0;
    localparam word_t W_DATA_IN    = 10'd1;
    localparam word_t W_DATA_OUT   = 10'd2;
    localparam word_t W_STATUS     = 10'd3;
    localparam word_t W_SAMPLE_CNT = 10'd4;
    localparam word_t W_RESULT_CNT = 10'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_IN_EMPTY  = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_OUT_EMPTY = 2;
    localparam int ST_OUT_FULL  = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UNF       = 5;
    localparam int ST_TMO       = 6;
    localparam int ST_BUSY      = 7;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// APB slave bus bundle for the FIR sequencer; the CPU side is the master.
interface fir_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/fir_seq_fifo.sv
// Synchronous FIFO with flush; a push is accepted while full if a pop
// happens in the same cycle. DEPTH must be a power of two.
module fir_seq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// APB-programmed sequencer feeding samples to a FIR core one at a time and
// buffering its results, with sticky error flags and a level interrupt.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT        = 64
) (
    input  logic           HCLK,
    input  logic           HRESET,
    fir_seq_ctrl_if.slave  apb,
    output logic           fir_ce,
    output logic [31:0]    fir_sample,
    input  logic [31:0]    fir_result,
    input  logic           fir_valid,
    output logic           irq
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              state, state_next;
    logic                en, irq_en, ovf, unf, tmo;
    logic [31:0]         sample_cnt, result_cnt, result_q;
    logic [CW-1:0]       wait_cnt;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                unused_addr_bits;
    word_t               word;
    logic                wr, rd, clr, timeout_evt;
    logic                in_push_req, in_pop, in_empty, in_full;
    logic                out_pop_req, out_pop, out_push, out_empty, out_full;
    logic                ovf_evt, unf_evt;
    logic [31:0]         in_head, out_head;
    logic [7:0]          status;

    assign paddr            = apb.PADDR;
    assign unused_addr_bits = ^paddr[1:0];
    assign word             = paddr[11:2];
    assign wr  = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd  = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign clr = wr && (word == W_CTRL) && apb.PWDATA[CTRL_CLR];

    assign in_push_req = wr && (word == W_DATA_IN);
    assign out_pop_req = rd && (word == W_DATA_OUT);
    assign in_pop      = (state == S_ISSUE);
    assign out_pop     = out_pop_req & ~out_empty;
    assign out_push    = (state == S_STORE);
    // A write to a full in-FIFO is still taken if ISSUE frees a slot this cycle.
    assign ovf_evt     = in_push_req & in_full & ~in_pop;
    assign unf_evt     = out_pop_req & out_empty;

    fir_seq_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(HCLK), .rst(HRESET), .flush(clr),
        .push(in_push_req), .pop(in_pop), .wdata(apb.PWDATA),
        .rdata(in_head), .empty(in_empty), .full(in_full)
    );

    fir_seq_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(HCLK), .rst(HRESET), .flush(clr),
        .push(out_push), .pop(out_pop), .wdata(result_q),
        .rdata(out_head), .empty(out_empty), .full(out_full)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        timeout_evt = 1'b0;
        case (state)
            S_IDLE:  if (en && !in_empty && (!out_full || out_pop))
                         state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (fir_valid) begin
                    state_next = S_STORE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_next  = S_IDLE;
                    timeout_evt = 1'b1;
                end
            end
            S_STORE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (clr)
            state_next = S_IDLE;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= S_IDLE;
            en         <= 1'b0;
            irq_en     <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            tmo        <= 1'b0;
            sample_cnt <= '0;
            result_cnt <= '0;
            result_q   <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            if (wr && word == W_CTRL) begin
                en     <= apb.PWDATA[CTRL_EN];
                irq_en <= apb.PWDATA[CTRL_IRQ_EN];
            end
            if (state == S_ISSUE)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_WAIT && fir_valid)
                result_q <= fir_result;
            if (clr) begin
                sample_cnt <= '0;
                result_cnt <= '0;
                ovf        <= 1'b0;
                unf        <= 1'b0;
                tmo        <= 1'b0;
            end else begin
                if (in_pop)   sample_cnt <= sample_cnt + 1'b1;
                if (out_push) result_cnt <= result_cnt + 1'b1;
                // Write-1-to-clear first so a same-cycle event keeps the flag set.
                if (wr && word == W_STATUS) begin
                    if (apb.PWDATA[ST_OVF]) ovf <= 1'b0;
                    if (apb.PWDATA[ST_UNF]) unf <= 1'b0;
                    if (apb.PWDATA[ST_TMO]) tmo <= 1'b0;
                end
                if (ovf_evt)     ovf <= 1'b1;
                if (unf_evt)     unf <= 1'b1;
                if (timeout_evt) tmo <= 1'b1;
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_IN_EMPTY]  = in_empty;
        status[ST_IN_FULL]   = in_full;
        status[ST_OUT_EMPTY] = out_empty;
        status[ST_OUT_FULL]  = out_full;
        status[ST_OVF]       = ovf;
        status[ST_UNF]       = unf;
        status[ST_TMO]       = tmo;
        status[ST_BUSY]      = (state != S_IDLE);
    end

    always_comb begin
        apb.PRDATA = UNMAPPED_RDATA;
        case (word)
            W_CTRL:       apb.PRDATA = {29'd0, irq_en, 1'b0, en};
            W_DATA_IN:    apb.PRDATA = '0;
            W_DATA_OUT:   apb.PRDATA = out_empty ? '0 : out_head;
            W_STATUS:     apb.PRDATA = {24'd0, status};
            W_SAMPLE_CNT: apb.PRDATA = sample_cnt;
            W_RESULT_CNT: apb.PRDATA = result_cnt;
            default:      apb.PRDATA = UNMAPPED_RDATA;
        endcase
    end

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = ~HRESET & (ovf_evt | unf_evt);
    assign fir_ce      = ~HRESET & (state == S_ISSUE);
    assign fir_sample  = fir_ce ? in_head : '0;
    assign irq         = ~HRESET & irq_en & (~out_empty | ovf | unf | tmo);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed + randomized bench for fir_seq_ctrl with a behavioural FIR core
// and a queue-based model of the expected result stream.
module tb_fir_seq_ctrl;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_DIN    = 12'h004;
    localparam logic [11:0] A_DOUT   = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;
    localparam logic [11:0] A_SCNT   = 12'h010;
    localparam logic [11:0] A_RCNT   = 12'h014;
    localparam logic [11:0] A_UNMAP  = 12'h01C;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        fir_ce, fir_valid, irq;
    logic [31:0] fir_sample, fir_result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int core_lat = 4;
    int ce_times[$];
    logic [31:0] exp_q[$];
    int total_res = 0;

    fir_seq_ctrl_if #(.ADDR_WIDTH(12)) bus ();

    fir_seq_ctrl #(.APB_ADDR_WIDTH(12), .FIFO_DEPTH(8), .TIMEOUT(64)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .apb(bus),
        .fir_ce(fir_ce), .fir_sample(fir_sample),
        .fir_result(fir_result), .fir_valid(fir_valid), .irq(irq)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;
    always @(negedge HCLK) if (fir_ce) ce_times.push_back(cyc);

    function automatic logic [31:0] core_f(input logic [31:0] s);
        return s * 32'd3 + 32'h0000_1357;
    endfunction

    // Behavioural core: answers core_lat cycles after the strobe, or never if negative.
    initial begin
        logic [31:0] s;
        fir_valid  = 1'b0;
        fir_result = '0;
        forever begin
            @(negedge HCLK);
            if (fir_ce && core_lat >= 0) begin
                s = fir_sample;
                repeat (core_lat) @(negedge HCLK);
                fir_result = core_f(s);
                fir_valid  = 1'b1;
                @(negedge HCLK);
                fir_valid  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(posedge HCLK); #1;
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge HCLK);
        err = bus.PSLVERR;
        @(posedge HCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(posedge HCLK); #1;
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge HCLK);
        d   = bus.PRDATA;
        err = bus.PSLVERR;
        @(posedge HCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_read(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic push_sample(input string tag, input logic [31:0] s);
        logic e;
        exp_q.push_back(core_f(s));
        total_res++;
        apb_write(A_DIN, s, e);
        check(tag, {31'd0, e}, 32'd0);
    endtask

    task automatic wait_results(input string tag, input int n);
        logic [31:0] d;
        logic e;
        for (int i = 0; i < 100; i++) begin
            apb_read(A_RCNT, d, e);
            if (d == n) break;
        end
        check(tag, d, n);
    endtask

    task automatic drain(input string tag, input int n);
        logic [31:0] d;
        logic e;
        for (int i = 0; i < n; i++) begin
            apb_read(A_DOUT, d, e);
            check(tag, d, exp_q.pop_front());
            check({tag, "_err"}, {31'd0, e}, 32'd0);
        end
    endtask

    task automatic wait_ce(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (fir_ce) break;
        end
        check(tag, {31'd0, fir_ce}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;

        // Reset
        repeat (3) @(negedge HCLK);
        check("rst_fir_ce", {31'd0, fir_ce}, 32'd0);
        check("rst_fir_sample", fir_sample, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        @(posedge HCLK); #1 HRESET = 1'b0;
        rd_check("rst_status", A_STATUS, 32'h0000_0005);
        rd_check("rst_ctrl", A_CTRL, 32'd0);
        apb_read(A_UNMAP, d, e);
        check("unmapped_rd", d, 32'hFFFF_FFFF);
        check("unmapped_rd_err", {31'd0, e}, 32'd0);
        apb_write(A_UNMAP, 32'h1234_5678, e);
        check("unmapped_wr_err", {31'd0, e}, 32'd0);
        apb_write(A_SCNT, 32'h0000_0077, e);
        rd_check("ro_write_ignored", A_SCNT, 32'd0);

        // Three samples, 4-cycle core latency
        core_lat = 4;
        wr(A_CTRL, 32'h1);
        ce_times.delete();
        for (int i = 0; i < 3; i++) push_sample("basic_push_err", $urandom);
        wait_results("basic_rcnt", 3);
        check("basic_ce_count", ce_times.size(), 3);
        if (ce_times.size() == 3) begin
            check("basic_ce_gap0", ce_times[1] - ce_times[0], 7);
            check("basic_ce_gap1", ce_times[2] - ce_times[1], 7);
        end
        drain("basic_dout", 3);
        rd_check("basic_scnt", A_SCNT, 32'd3);
        rd_check("basic_rcnt_final", A_RCNT, 32'd3);

        // Randomized batches against the queue model
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 8);
            core_lat = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_sample("rnd_push_err", $urandom);
            wait_results("rnd_rcnt", total_res);
            drain("rnd_dout", n);
        end
        rd_check("rnd_scnt", A_SCNT, total_res);

        // Out-FIFO full back-pressure
        core_lat = 2;
        for (int i = 0; i < 8; i++) push_sample("full_push_err", $urandom);
        wait_results("full_rcnt", total_res);
        rd_check("full_status", A_STATUS, 32'h0000_0009);
        push_sample("full_push9_err", $urandom);
        ce_times.delete();
        repeat (20) @(negedge HCLK);
        check("full_no_ce", ce_times.size(), 0);
        apb_read(A_DOUT, d, e);
        check("full_first_pop", d, exp_q.pop_front());
        @(negedge HCLK);
        check("full_ce_after_pop", {31'd0, fir_ce}, 32'd1);
        wait_results("full_rcnt2", total_res);
        drain("full_dout", 8);

        // Overflow / underflow / irq with EN=0
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apb_write(A_DIN, $urandom, e);
            check("ovf_fill_err", {31'd0, e}, 32'd0);
        end
        apb_write(A_DIN, $urandom, e);
        check("ovf_9th_err", {31'd0, e}, 32'd1);
        rd_check("ovf_status", A_STATUS, 32'h0000_0016);
        apb_read(A_DOUT, d, e);
        check("unf_data", d, 32'd0);
        check("unf_err", {31'd0, e}, 32'd1);
        rd_check("unf_status", A_STATUS, 32'h0000_0036);
        check("irq_disabled", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h4);
        check("irq_enabled", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'h70);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h2);
        rd_check("clr_status", A_STATUS, 32'h0000_0005);
        rd_check("clr_scnt", A_SCNT, 32'd0);
        exp_q.delete();
        total_res = 0;

        // Timeout: core never answers
        wr(A_CTRL, 32'h5);
        core_lat = -1;
        wr(A_DIN, $urandom);
        wait_ce("tmo_ce");
        for (int k = 1; k <= 65; k++) begin
            @(negedge HCLK);
            if (k == 64) check("tmo_not_yet", {31'd0, irq}, 32'd0);
            if (k == 65) check("tmo_set", {31'd0, irq}, 32'd1);
        end
        rd_check("tmo_status", A_STATUS, 32'h0000_0045);
        rd_check("tmo_scnt", A_SCNT, 32'd1);
        rd_check("tmo_rcnt", A_RCNT, 32'd0);
        wr(A_STATUS, 32'h40);
        rd_check("tmo_cleared", A_STATUS, 32'h0000_0005);

        // CLR during WAIT, late fir_valid ignored
        wr(A_CTRL, 32'h1);
        core_lat = 10;
        wr(A_DIN, $urandom);
        wait_ce("clrw_ce");
        wr(A_CTRL, 32'h3);
        rd_check("clrw_status", A_STATUS, 32'h0000_0005);
        rd_check("clrw_scnt", A_SCNT, 32'd0);
        repeat (15) @(negedge HCLK);
        rd_check("clrw_status_late", A_STATUS, 32'h0000_0005);
        rd_check("clrw_rcnt_late", A_RCNT, 32'd0);

        // Reset mid-WAIT aborts the sample
        wr(A_DIN, $urandom);
        wait_ce("rstw_ce");
        @(posedge HCLK); #1 HRESET = 1'b1;
        @(negedge HCLK);
        check("rstw_ce_low", {31'd0, fir_ce}, 32'd0);
        check("rstw_irq_low", {31'd0, irq}, 32'd0);
        @(posedge HCLK); #1 HRESET = 1'b0;
        repeat (15) @(negedge HCLK);
        rd_check("rstw_status", A_STATUS, 32'h0000_0005);
        rd_check("rstw_rcnt", A_RCNT, 32'd0);
        rd_check("rstw_ctrl", A_CTRL, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
